sram_dual_master_sched: RTL and testbench
=========================================

Name: sram_dual_master_sched

Overview:
- Schedules two independent requesters (M0, M1) onto one sky130 1rw1r 32x512 SRAM macro.
- Write traffic goes to port 0 (RW). Reads are steered to port 1 (R) or to an idle port 0, so up to two accesses complete per cycle.
- Write/write contention is resolved round-robin. Same-cycle cross-master read-after-write to one address is hazard-blocked.
- Sits between user-project bus adapters and the SRAM macro. The macro clocks clk0/clk1 are tied to wb_clk_i at top level.

Parameters:
- ADDR_WIDTH, 9, word address width
- DATA_WIDTH, 32, data width
- NUM_WMASKS, 4, byte-lane write-mask width (DATA_WIDTH/8)

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  asynchronous reset, active high
- mX_valid  in  1  request valid (X = 0,1; each port below exists per master)
- mX_ready  out  1  request accepted this cycle (valid & ready at posedge)
- mX_we  in  1  1 = write, 0 = read
- mX_wmask  in  NUM_WMASKS  byte-lane enables for writes
- mX_addr  in  ADDR_WIDTH  word address
- mX_wdata  in  DATA_WIDTH  write data
- mX_rsp_valid  out  1  read data valid, one-cycle pulse
- mX_rdata  out  DATA_WIDTH  read data, qualified by mX_rsp_valid
- sram_csb0  out  1  port0 chip select, active low
- sram_web0  out  1  port0 write enable, active low
- sram_wmask0  out  NUM_WMASKS  port0 write mask
- sram_addr0  out  ADDR_WIDTH  port0 address
- sram_din0  out  DATA_WIDTH  port0 write data
- sram_dout0  in  DATA_WIDTH  port0 read data
- sram_csb1  out  1  port1 chip select, active low
- sram_addr1  out  ADDR_WIDTH  port1 address
- sram_dout1  in  DATA_WIDTH  port1 read data

Behaviour:
- Grant logic is combinational from the mX_* inputs and state. SRAM pins are driven combinationally from the granted requests, so the macro samples them at the same posedge where valid&ready.
- Unused port: csb high. Address, din and mask are don't-care but are held at the M0 values to limit toggling.
- Grant rules, evaluated each cycle:
  - Single read → port1.
  - Single write → port0.
  - Read + read → M0 on port1, M1 on port0; both ready.
  - Write + read (different masters) → write on port0, read on port1; both ready. Exception: if the addresses are equal, the read is NOT accepted this cycle (ready=0) and is retried next cycle, so it returns the post-write data.
  - Write + write → only the master indicated by rr_prio is granted; the other stalls.
  - rr_prio flips to the loser only on a write/write conflict grant. It is unchanged otherwise, including on hazard deferral.
- Read latency is 1 cycle. For a read accepted at posedge T:
  - mX_rsp_valid = 1 from T to T+1.
  - mX_rdata = the dout of the port used, recorded in a per-master registered port-select bit. The macro updates dout at the negedge after T, so data is stable at posedge T+1.
- Writes produce no response and complete at the negedge after acceptance.
- No buffering. Requests are not required to be held after acceptance. Responses have no backpressure.
- A master with valid=0 is never granted; ready is 0 whenever valid is 0.
- wmask = 0 on a write is legal: port0 is used and memory is unchanged.
- Reset (async, any time), held while wb_rst_i is high:
  - mX_ready = 0, mX_rsp_valid = 0, mX_rdata = 0, sram_csb0 = sram_csb1 = 1, sram_web0 = 1.
  - rr_prio = M0, port-select bits = port1.
- Reset mid-read: the pending rsp_valid is dropped. A write sampled at the same posedge that reset asserts is not guaranteed.

Test Plan:
- M0 writes 0xDEADBEEF @0x010 with wmask 0xF, then M1 reads 0x010 → M1_rsp_valid one cycle after accept, rdata 0xDEADBEEF, served on port1.
- Same cycle: M0 reads 0x005 and M1 reads 0x006, both preloaded (0x55, 0x66) → both ready; next cycle M0 rdata 0x55 via port1, M1 rdata 0x66 via port0.
- M0 and M1 both write, held valid for 4 cycles → grants alternate M0, M1, M0, M1; sram_web0 = 0 each cycle; rr_prio toggles.
- M0 writes 0x1234_5678 @0x020 while M1 reads 0x020 (old value 0) → M1 ready = 0 that cycle; accepted next cycle; rdata 0x12345678.
- Byte mask: word 0xAAAAAAAA, M1 writes 0x11223344 with wmask 0b0101 → readback 0xAA22AA44.
- Assert wb_rst_i asynchronously mid-cycle one cycle after a read accept → rsp_valid falls to 0 immediately, csb0/csb1 = 1, no response after release, and the next write/write conflict grants M0 first.

Source files
------------

// File: rtl/sram_dual_master_sched.sv
// Purpose : schedules two requesters (M0, M1) onto a 1rw1r SRAM macro; writes use port0,
//           reads use port1 or an otherwise idle port0, so up to two accesses per cycle.
// Latency : grant and SRAM pins are combinational; read data returns one cycle after accept.
//           Backpressure: mX_ready stalls the write/write loser and a same-address cross-master
//           read; responses have no backpressure and nothing is buffered.
// Ports   : wb_clk_i/wb_rst_i (async, active high); per master valid/ready/we/wmask/addr/wdata
//           request and rsp_valid/rdata response; sram_* pins for port0 (RW) and port1 (R).
module sram_dual_master_sched #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,

    input  logic                  m0_valid,
    output logic                  m0_ready,
    input  logic                  m0_we,
    input  logic [NUM_WMASKS-1:0] m0_wmask,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_rsp_valid,
    output logic [DATA_WIDTH-1:0] m0_rdata,

    input  logic                  m1_valid,
    output logic                  m1_ready,
    input  logic                  m1_we,
    input  logic [NUM_WMASKS-1:0] m1_wmask,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_rsp_valid,
    output logic [DATA_WIDTH-1:0] m1_rdata,

    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);

    logic rd0, wr0, rd1, wr1;
    logic grant0, grant1;
    logic p0_use, p0_wr, p0_m1;    // port0 active, port0 writing, port0 owned by M1
    logic p1_use, p1_m1;           // port1 active, port1 owned by M1
    logic same_addr;

    logic rr_prio;                 // 0: M0 wins the next write/write conflict, 1: M1 wins
    logic rsp0_q, rsp1_q;
    logic sel0_p0_q, sel1_p0_q;    // response for this master comes from port0 (else port1)

    assign rd0       = m0_valid & ~m0_we;
    assign wr0       = m0_valid &  m0_we;
    assign rd1       = m1_valid & ~m1_we;
    assign wr1       = m1_valid &  m1_we;
    assign same_addr = (m0_addr == m1_addr);

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        p0_use = 1'b0;
        p0_wr  = 1'b0;
        p0_m1  = 1'b0;
        p1_use = 1'b0;
        p1_m1  = 1'b0;
        if (!wb_rst_i) begin
            if (wr0 && wr1) begin
                p0_use = 1'b1;
                p0_wr  = 1'b1;
                if (rr_prio) begin
                    grant1 = 1'b1;
                    p0_m1  = 1'b1;
                end else begin
                    grant0 = 1'b1;
                end
            end else if (wr0) begin
                grant0 = 1'b1;
                p0_use = 1'b1;
                p0_wr  = 1'b1;
                // Same-address read waits a cycle so it observes the new data.
                if (rd1 && !same_addr) begin
                    grant1 = 1'b1;
                    p1_use = 1'b1;
                    p1_m1  = 1'b1;
                end
            end else if (wr1) begin
                grant1 = 1'b1;
                p0_use = 1'b1;
                p0_wr  = 1'b1;
                p0_m1  = 1'b1;
                if (rd0 && !same_addr) begin
                    grant0 = 1'b1;
                    p1_use = 1'b1;
                end
            end else begin
                if (rd0) begin
                    grant0 = 1'b1;
                    p1_use = 1'b1;
                end
                if (rd1) begin
                    grant1 = 1'b1;
                    if (rd0) begin
                        // Port1 already taken by M0; port0 is idle, so M1 reads there.
                        p0_use = 1'b1;
                        p0_m1  = 1'b1;
                    end else begin
                        p1_use = 1'b1;
                        p1_m1  = 1'b1;
                    end
                end
            end
        end
    end

    assign m0_ready = grant0;
    assign m1_ready = grant1;

    // Idle port pins follow M0 so the macro inputs toggle less.
    assign sram_csb0   = ~p0_use;
    assign sram_web0   = ~p0_wr;
    assign sram_addr0  = p0_m1 ? m1_addr  : m0_addr;
    assign sram_din0   = p0_m1 ? m1_wdata : m0_wdata;
    assign sram_wmask0 = p0_m1 ? m1_wmask : m0_wmask;
    assign sram_csb1   = ~p1_use;
    assign sram_addr1  = p1_m1 ? m1_addr  : m0_addr;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rr_prio   <= 1'b0;
            rsp0_q    <= 1'b0;
            rsp1_q    <= 1'b0;
            sel0_p0_q <= 1'b0;
            sel1_p0_q <= 1'b0;
        end else begin
            // Conflict winner was rr_prio, so toggling hands priority to the loser.
            if (wr0 && wr1)
                rr_prio <= ~rr_prio;
            rsp0_q <= grant0 & rd0;
            rsp1_q <= grant1 & rd1;
            if (grant0 && rd0)
                sel0_p0_q <= p0_use & ~p0_wr & ~p0_m1;
            if (grant1 && rd1)
                sel1_p0_q <= p0_use & ~p0_wr & p0_m1;
        end
    end

    assign m0_rsp_valid = rsp0_q;
    assign m1_rsp_valid = rsp1_q;
    assign m0_rdata     = rsp0_q ? (sel0_p0_q ? sram_dout0 : sram_dout1) : '0;
    assign m1_rdata     = rsp1_q ? (sel1_p0_q ? sram_dout0 : sram_dout1) : '0;

endmodule

// File: tb/tb_sram_dual_master_sched.sv
module tb_sram_dual_master_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        m0_valid, m0_ready, m0_we, m0_rsp_valid;
    logic [3:0]  m0_wmask;
    logic [8:0]  m0_addr;
    logic [31:0] m0_wdata, m0_rdata;
    logic        m1_valid, m1_ready, m1_we, m1_rsp_valid;
    logic [3:0]  m1_wmask;
    logic [8:0]  m1_addr;
    logic [31:0] m1_wdata, m1_rdata;

    logic        sram_csb0, sram_web0, sram_csb1;
    logic [3:0]  sram_wmask0;
    logic [8:0]  sram_addr0, sram_addr1;
    logic [31:0] sram_din0;
    logic [31:0] sram_dout0 = 32'h0;
    logic [31:0] sram_dout1 = 32'h0;

    int total = 0;
    int bad   = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];

    sram_dual_master_sched #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .NUM_WMASKS(4)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_we(m0_we), .m0_wmask(m0_wmask),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rsp_valid(m0_rsp_valid), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_we(m1_we), .m1_wmask(m1_wmask),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rsp_valid(m1_rsp_valid), .m1_rdata(m1_rdata),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
        .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
    );

    initial forever #5 clk = ~clk;

    // SRAM macro model: pins sampled at posedge, array and dout updated at the next negedge.
    // Reads see the array contents from before a same-cycle write.
    logic [31:0] mem [0:511];
    logic        c_p0_en = 1'b0, c_p0_we = 1'b0, c_p1_en = 1'b0;
    logic [8:0]  c_a0 = 9'h0, c_a1 = 9'h0;
    logic [31:0] c_din = 32'h0;
    logic [3:0]  c_mask = 4'h0;

    always @(posedge clk) begin
        c_p0_en <= ~sram_csb0;
        c_p0_we <= ~sram_web0;
        c_p1_en <= ~sram_csb1;
        c_a0    <= sram_addr0;
        c_a1    <= sram_addr1;
        c_din   <= sram_din0;
        c_mask  <= sram_wmask0;
    end

    always @(negedge clk) begin
        if (c_p1_en)
            sram_dout1 <= mem[c_a1];
        if (c_p0_en && !c_p0_we)
            sram_dout0 <= mem[c_a0];
        if (c_p0_en && c_p0_we)
            for (int b = 0; b < 4; b++)
                if (c_mask[b])
                    mem[c_a0][8*b +: 8] <= c_din[8*b +: 8];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Response scoreboard: sampled late in the cycle, well away from either clock edge.
    always @(negedge clk) begin
        #3;
        if (m0_rsp_valid) begin
            if (q0.size() == 0) chk("m0_unexpected_rsp", 32'(m0_rsp_valid), 32'd0);
            else                chk("m0_rdata", m0_rdata, q0.pop_front());
        end
        if (m1_rsp_valid) begin
            if (q1.size() == 0) chk("m1_unexpected_rsp", 32'(m1_rsp_valid), 32'd0);
            else                chk("m1_rdata", m1_rdata, q1.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m0(input logic v, input logic we, input logic [8:0] a,
                          input logic [31:0] d, input logic [3:0] m);
        m0_valid = v; m0_we = we; m0_addr = a; m0_wdata = d; m0_wmask = m;
    endtask

    task automatic set_m1(input logic v, input logic we, input logic [8:0] a,
                          input logic [31:0] d, input logic [3:0] m);
        m1_valid = v; m1_we = we; m1_addr = a; m1_wdata = d; m1_wmask = m;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        mem[5]      = 32'h0000_0055;
        mem[6]      = 32'h0000_0066;
        mem[9'h030] = 32'hAAAA_AAAA;

        // Reset: requests present but nothing may be granted or driven.
        set_m0(1'b1, 1'b1, 9'h001, 32'h1, 4'hF);
        set_m1(1'b1, 1'b0, 9'h002, 32'h0, 4'h0);
        #2;
        chk("rst_m0_ready",  32'(m0_ready), 32'd0);
        chk("rst_m1_ready",  32'(m1_ready), 32'd0);
        chk("rst_csb0",      32'(sram_csb0), 32'd1);
        chk("rst_csb1",      32'(sram_csb1), 32'd1);
        chk("rst_web0",      32'(sram_web0), 32'd1);
        chk("rst_m0_rsp",    32'(m0_rsp_valid), 32'd0);
        chk("rst_m1_rdata",  m1_rdata, 32'd0);
        step(); step();
        rst = 1'b0;
        set_m0(1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
        set_m1(1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
        step();

        // M0 write then M1 read of the same word via port1.
        set_m0(1'b1, 1'b1, 9'h010, 32'hDEAD_BEEF, 4'hF);
        #1;
        chk("w_m0_ready", 32'(m0_ready), 32'd1);
        chk("w_web0",     32'(sram_web0), 32'd0);
        chk("w_csb0",     32'(sram_csb0), 32'd0);
        chk("w_addr0",    32'(sram_addr0), 32'h010);
        chk("w_din0",     sram_din0, 32'hDEAD_BEEF);
        step();
        set_m0(1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
        set_m1(1'b1, 1'b0, 9'h010, 32'h0, 4'h0);
        #1;
        chk("r_m1_ready", 32'(m1_ready), 32'd1);
        chk("r_csb1",     32'(sram_csb1), 32'd0);
        chk("r_csb0",     32'(sram_csb0), 32'd1);
        chk("r_addr1",    32'(sram_addr1), 32'h010);
        q1.push_back(32'hDEAD_BEEF);
        step();
        set_m1(1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
        #1;
        chk("r_m1_rsp_lat", 32'(m1_rsp_valid), 32'd1);
        step();

        // Read + read: M0 on port1, M1 on port0.
        set_m0(1'b1, 1'b0, 9'h005, 32'h0, 4'h0);
        set_m1(1'b1, 1'b0, 9'h006, 32'h0, 4'h0);
        #1;
        chk("rr_m0_ready", 32'(m0_ready), 32'd1);
        chk("rr_m1_ready", 32'(m1_ready), 32'd1);
        chk("rr_csb0",     32'(sram_csb0), 32'd0);
        chk("rr_web0",     32'(sram_web0), 32'd1);
        chk("rr_addr1",    32'(sram_addr1), 32'h005);
        chk("rr_addr0",    32'(sram_addr0), 32'h006);
        q0.push_back(32'h55);
        q1.push_back(32'h66);
        step();
        set_m0(1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
        set_m1(1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
        #1;
        chk("rr_m0_rsp", 32'(m0_rsp_valid), 32'd1);
        step();

        // Write/write held four cycles: grants alternate starting with M0.
        set_m0(1'b1, 1'b1, 9'h040, 32'h0000_00A0, 4'hF);
        set_m1(1'b1, 1'b1, 9'h041, 32'h0000_00B1, 4'hF);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("ww_m0_ready", 32'(m0_ready), 32'(i % 2 == 0));
            chk("ww_m1_ready", 32'(m1_ready), 32'(i % 2 == 1));
            chk("ww_web0",     32'(sram_web0), 32'd0);
            chk("ww_addr0",    32'(sram_addr0), (i % 2 == 0) ? 32'h040 : 32'h041);
            step();
        end
        set_m0(1'b1, 1'b0, 9'h041, 32'h0, 4'h0);
        set_m1(1'b1, 1'b0, 9'h040, 32'h0, 4'h0);
        q0.push_back(32'h0000_00B1);
        q1.push_back(32'h0000_00A0);
        step();
        set_m0(1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
        set_m1(1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
        step();

        // Same-address write/read hazard: read deferred one cycle.
        set_m0(1'b1, 1'b1, 9'h020, 32'h1234_5678, 4'hF);
        set_m1(1'b1, 1'b0, 9'h020, 32'h0, 4'h0);
        #1;
        chk("hz_m0_ready", 32'(m0_ready), 32'd1);
        chk("hz_m1_ready", 32'(m1_ready), 32'd0);
        chk("hz_csb1",     32'(sram_csb1), 32'd1);
        step();
        set_m0(1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
        #1;
        chk("hz_m1_retry", 32'(m1_ready), 32'd1);
        q1.push_back(32'h1234_5678);
        step();
        set_m1(1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
        step();

        // Different-address write + read proceed together.
        set_m1(1'b1, 1'b1, 9'h021, 32'h0000_0077, 4'hF);
        set_m0(1'b1, 1'b0, 9'h010, 32'h0, 4'h0);
        #1;
        chk("wr_m0_ready", 32'(m0_ready), 32'd1);
        chk("wr_m1_ready", 32'(m1_ready), 32'd1);
        chk("wr_csb1",     32'(sram_csb1), 32'd0);
        chk("wr_addr0",    32'(sram_addr0), 32'h021);
        q0.push_back(32'hDEAD_BEEF);
        step();
        set_m0(1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
        set_m1(1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
        step();

        // Byte-lane write, then a zero-mask write that must leave memory unchanged.
        set_m1(1'b1, 1'b1, 9'h030, 32'h1122_3344, 4'b0101);
        #1;
        chk("bm_m1_ready", 32'(m1_ready), 32'd1);
        chk("bm_wmask0",   32'(sram_wmask0), 32'h5);
        step();
        set_m1(1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
        set_m0(1'b1, 1'b1, 9'h030, 32'hFFFF_FFFF, 4'h0);
        #1;
        chk("m0w_m0_ready", 32'(m0_ready), 32'd1);
        chk("m0w_csb0",     32'(sram_csb0), 32'd0);
        chk("m0w_web0",     32'(sram_web0), 32'd0);
        step();
        set_m0(1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
        set_m1(1'b1, 1'b0, 9'h030, 32'h0, 4'h0);
        q1.push_back(32'hAA22_AA44);
        step();
        set_m1(1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
        step();

        // One conflict leaves priority with M1 before reset.
        set_m0(1'b1, 1'b1, 9'h050, 32'h1, 4'hF);
        set_m1(1'b1, 1'b1, 9'h051, 32'h2, 4'hF);
        #1;
        chk("pre_m0_ready", 32'(m0_ready), 32'd1);
        step();
        chk("pre_m1_ready", 32'(m1_ready), 32'd1);
        chk("pre_m0_stall", 32'(m0_ready), 32'd0);
        set_m0(1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
        set_m1(1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
        step();

        // Reset mid-read: pending response dropped at once.
        set_m0(1'b1, 1'b0, 9'h010, 32'h0, 4'h0);
        #1;
        chk("mr_m0_ready", 32'(m0_ready), 32'd1);
        step();
        set_m0(1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
        #1;
        chk("mr_rsp_before", 32'(m0_rsp_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mr_rsp_drop",   32'(m0_rsp_valid), 32'd0);
        chk("mr_rdata_zero", m0_rdata, 32'd0);
        chk("mr_csb0",       32'(sram_csb0), 32'd1);
        chk("mr_csb1",       32'(sram_csb1), 32'd1);
        step(); step();
        rst = 1'b0;
        #1;
        chk("mr_no_rsp_a", 32'(m0_rsp_valid), 32'd0);
        step();
        chk("mr_no_rsp_b", 32'(m0_rsp_valid), 32'd0);

        // Priority back at M0 after reset.
        set_m0(1'b1, 1'b1, 9'h060, 32'h3, 4'hF);
        set_m1(1'b1, 1'b1, 9'h061, 32'h4, 4'hF);
        #1;
        chk("prst_m0_ready", 32'(m0_ready), 32'd1);
        chk("prst_m1_ready", 32'(m1_ready), 32'd0);
        step();
        chk("prst_m1_next", 32'(m1_ready), 32'd1);
        set_m0(1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
        set_m1(1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
        step(); step();

        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
